// File: rtl/timera_counter.sv
// ============================================================================
// Module   : timera_counter
// Brief    : TimerA counting core - synchronises TimerClock into MCLK and
//            advances TAR in stop/up/continuous/up-down modes.
// Revision : 1.0
// ============================================================================
`default_nettype none

module timera_counter #(
    parameter int WIDTH = 16
) (
    input  logic             MCLK,
    input  logic             reset_n,
    input  logic             TimerClock,
    input  logic [1:0]       MC,
    input  logic [WIDTH-1:0] TACCR0,
    input  logic             wTACLR,
    input  logic             wTAR,
    input  logic [WIDTH-1:0] TARin,
    input  logic             TAIE,
    input  logic             wTAIFGclr,
    output logic [WIDTH-1:0] TAR,
    output logic             TAIFG,
    output logic             TAIRQ,
    output logic             EQU0,
    output logic             dir
);

    localparam logic [1:0]       c_MC_STOP = 2'b00;
    localparam logic [1:0]       c_MC_UP   = 2'b01;
    localparam logic [1:0]       c_MC_CONT = 2'b10;
    localparam logic [1:0]       c_MC_UPDN = 2'b11;
    localparam logic [WIDTH-1:0] c_ZERO    = '0;
    localparam logic [WIDTH-1:0] c_ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] c_ONES    = '1;

    logic             r_s1, r_s2, r_sp;
    logic [1:0]       r_mc_prev;
    logic [WIDTH-1:0] r_tar;
    logic             r_taifg, r_equ0, r_dir;

    logic             w_tick, w_adv, w_set, w_equ, w_mc_wr, w_dir_nxt;
    logic [WIDTH-1:0] w_tar_nxt;

    assign w_tick  = r_s2 & ~r_sp;
    // A software write on the tick cycle swallows that tick entirely.
    assign w_adv   = w_tick & (MC != c_MC_STOP) & ~wTACLR & ~wTAR;
    assign w_mc_wr = (MC != r_mc_prev) & (MC != c_MC_UPDN);

    always_comb begin
        w_tar_nxt = r_tar;
        w_dir_nxt = r_dir;
        w_set     = 1'b0;
        case (MC)
            c_MC_UP: begin
                if (TACCR0 == c_ZERO) begin
                    w_tar_nxt = c_ZERO;
                end else if (r_tar >= TACCR0) begin
                    w_tar_nxt = c_ZERO;
                    w_set     = 1'b1;
                end else begin
                    w_tar_nxt = r_tar + c_ONE;
                end
            end
            c_MC_CONT: begin
                w_tar_nxt = r_tar + c_ONE;
                w_set     = (r_tar == c_ONES);
            end
            c_MC_UPDN: begin
                if (!r_dir) begin
                    if (r_tar >= TACCR0) begin
                        if (TACCR0 == c_ZERO) begin
                            w_tar_nxt = c_ZERO;
                        end else begin
                            w_dir_nxt = 1'b1;
                            w_tar_nxt = r_tar - c_ONE;
                        end
                    end else begin
                        w_tar_nxt = r_tar + c_ONE;
                    end
                end else if (r_tar == c_ZERO) begin
                    w_dir_nxt = 1'b0;
                    w_tar_nxt = c_ONE;
                end else begin
                    w_tar_nxt = r_tar - c_ONE;
                    w_set     = (r_tar == c_ONE);
                end
            end
            default: ;
        endcase
    end

    // A tick that leaves TAR where it was (TACCR0 = 0 hold) is not a match event.
    assign w_equ = w_adv & (w_tar_nxt == TACCR0) & (w_tar_nxt != r_tar);

    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_sp      <= 1'b0;
            r_mc_prev <= 2'b00;
            r_tar     <= c_ZERO;
            r_taifg   <= 1'b0;
            r_equ0    <= 1'b0;
            r_dir     <= 1'b0;
        end else begin
            r_s1      <= TimerClock;
            r_s2      <= r_s1;
            r_sp      <= r_s2;
            r_mc_prev <= MC;
            r_equ0    <= w_equ;
            r_taifg   <= (w_adv & w_set) | (r_taifg & ~wTAIFGclr);
            if (wTACLR) begin
                r_tar <= c_ZERO;
                r_dir <= 1'b0;
            end else if (wTAR) begin
                r_tar <= TARin;
            end else if (w_adv) begin
                r_tar <= w_tar_nxt;
                r_dir <= w_dir_nxt;
            end
            if (w_mc_wr) begin
                r_dir <= 1'b0;
            end
        end
    end

    assign TAR   = r_tar;
    assign TAIFG = r_taifg;
    assign TAIRQ = r_taifg & TAIE;
    assign EQU0  = r_equ0;
    assign dir   = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_timera_counter.sv
// ============================================================================
// Module   : tb_timera_counter
// Brief    : Scoreboard bench for timera_counter with directed tick sequences.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_timera_counter;

    logic        MCLK = 1'b0;
    logic        reset_n, TimerClock, wTACLR, wTAR, TAIE, wTAIFGclr;
    logic [1:0]  MC;
    logic [15:0] TACCR0, TARin, TAR;
    logic        TAIFG, TAIRQ, EQU0, dir;

    typedef struct packed {
        logic [15:0] tar;
        logic        flag;
        logic        dr;
        logic        equ;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    logic mon_en = 1'b0;

    timera_counter #(.WIDTH(16)) dut (
        .MCLK(MCLK), .reset_n(reset_n), .TimerClock(TimerClock), .MC(MC),
        .TACCR0(TACCR0), .wTACLR(wTACLR), .wTAR(wTAR), .TARin(TARin),
        .TAIE(TAIE), .wTAIFGclr(wTAIFGclr), .TAR(TAR), .TAIFG(TAIFG),
        .TAIRQ(TAIRQ), .EQU0(EQU0), .dir(dir)
    );

    always #5 MCLK = ~MCLK;

    // Monitor: every TAR change must match the next queued expectation.
    initial begin
        logic [15:0] prev;
        exp_t        e, a;
        prev = '0;
        forever begin
            @(negedge MCLK);
            if (mon_en) begin
                a = '{tar: TAR, flag: TAIFG, dr: dir, equ: EQU0};
                if (TAR !== prev) begin
                    tests++;
                    if (q.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_update: TAR=%h flag=%b dir=%b equ=%b, nothing expected",
                                 TAR, TAIFG, dir, EQU0);
                    end else begin
                        e = q.pop_front();
                        if (a !== e) begin
                            fails++;
                            $display("FAIL update: got TAR=%h flag=%b dir=%b equ=%b, want TAR=%h flag=%b dir=%b equ=%b",
                                     a.tar, a.flag, a.dr, a.equ, e.tar, e.flag, e.dr, e.equ);
                        end
                    end
                end else if (EQU0 !== 1'b0) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_equ0: EQU0=%b with TAR=%h unchanged, want 0", EQU0, TAR);
                end
            end
            prev = TAR;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge MCLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] t, input logic f, input logic d, input logic eq);
        q.push_back('{tar: t, flag: f, dr: d, equ: eq});
    endtask

    task automatic tick();
        TimerClock = 1'b1;
        cyc(3);
        TimerClock = 1'b0;
        cyc(3);
    endtask

    // Tick whose TAR-update edge coincides with a wTACLR (sel=1) or wTAIFGclr (sel=0) pulse.
    task automatic tick_with(input bit sel);
        TimerClock = 1'b1;
        cyc(2);
        if (sel) wTACLR = 1'b1; else wTAIFGclr = 1'b1;
        cyc(1);
        wTACLR = 1'b0;
        wTAIFGclr = 1'b0;
        cyc(1);
        TimerClock = 1'b0;
        cyc(3);
    endtask

    task automatic write_tar(input logic [15:0] v);
        TARin = v;
        wTAR  = 1'b1;
        cyc(1);
        wTAR  = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_clr();
        wTACLR = 1'b1;
        cyc(1);
        wTACLR = 1'b0;
        cyc(1);
    endtask

    task automatic pulse_fclr();
        wTAIFGclr = 1'b1;
        cyc(1);
        wTAIFGclr = 1'b0;
        cyc(1);
    endtask

    task automatic drain(input string nm);
        for (int n = 0; n < 30; n++) begin
            if (q.size() == 0) break;
            cyc(1);
        end
        cyc(2);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d expected updates outstanding, want 0", nm, q.size());
            q.delete();
        end
    endtask

    initial begin
        logic [15:0] up_t [9]   = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
        logic        up_e [9]   = '{0, 0, 1, 0, 0, 0, 1, 0, 0};
        logic        up_f [9]   = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
        logic [15:0] ud_t [8]   = '{16'd1, 16'd2, 16'd1, 16'd0, 16'd1, 16'd2, 16'd1, 16'd0};
        logic        ud_d [8]   = '{0, 0, 1, 1, 0, 0, 1, 1};
        logic        ud_e [8]   = '{0, 1, 0, 0, 0, 1, 0, 0};
        logic        ud_f [8]   = '{0, 0, 0, 1, 1, 1, 1, 1};

        reset_n = 1'b0; TimerClock = 1'b0; MC = 2'b10; TACCR0 = '0;
        wTACLR = 1'b0; wTAR = 1'b0; TARin = '0; TAIE = 1'b1; wTAIFGclr = 1'b0;

        // Reset while TimerClock toggles
        for (int i = 0; i < 4; i++) begin
            TimerClock = ~TimerClock;
            cyc(1);
        end
        chk("reset_TAR", {16'h0, TAR}, 32'h0);
        chk("reset_TAIFG", {31'h0, TAIFG}, 32'h0);
        chk("reset_dir", {31'h0, dir}, 32'h0);
        chk("reset_EQU0", {31'h0, EQU0}, 32'h0);
        chk("reset_TAIRQ", {31'h0, TAIRQ}, 32'h0);
        TimerClock = 1'b0;
        cyc(1);
        reset_n = 1'b1;
        cyc(3);
        mon_en = 1'b1;
        cyc(1);

        // First rise after release, continuous mode: TAR = 1 within 3 cycles
        push(16'd1, 0, 0, 0);
        TimerClock = 1'b1;
        cyc(3);
        chk("first_tick_latency", {16'h0, TAR}, 32'd1);
        TimerClock = 1'b0;
        cyc(3);
        drain("first_tick");

        // Up mode, TACCR0 = 3
        push(16'd0, 0, 0, 0);
        pulse_clr();
        MC = 2'b01; TACCR0 = 16'd3;
        cyc(2);
        for (int i = 0; i < 9; i++) begin
            push(up_t[i], up_f[i], 1'b0, up_e[i]);
            tick();
        end
        drain("up");
        chk("up_TAIRQ", {31'h0, TAIRQ}, 32'd1);
        pulse_fclr();
        chk("fclr_TAIFG", {31'h0, TAIFG}, 32'd0);
        chk("fclr_TAIRQ", {31'h0, TAIRQ}, 32'd0);

        // Continuous wrap, then set-wins against wTAIFGclr
        MC = 2'b10;
        cyc(2);
        push(16'hFFFE, 0, 0, 0);
        write_tar(16'hFFFE);
        push(16'hFFFF, 0, 0, 0);
        tick();
        push(16'h0000, 1, 0, 0);
        tick();
        drain("cont_wrap");
        push(16'hFFFF, 1, 0, 0);
        write_tar(16'hFFFF);
        push(16'h0000, 1, 0, 0);
        tick_with(1'b0);
        drain("cont_setwins");
        chk("setwins_TAIFG", {31'h0, TAIFG}, 32'd1);
        pulse_fclr();

        // Up/down, TACCR0 = 2, from 0
        MC = 2'b11; TACCR0 = 16'd2;
        cyc(2);
        for (int i = 0; i < 8; i++) begin
            push(ud_t[i], ud_f[i], ud_d[i], ud_e[i]);
            tick();
        end
        drain("updown");
        chk("updown_dir_end", {31'h0, dir}, 32'd1);
        MC = 2'b01;
        cyc(2);
        chk("modewrite_dir", {31'h0, dir}, 32'd0);
        pulse_fclr();

        // Up mode, TACCR0 lowered below TAR
        TACCR0 = 16'd20;
        push(16'd10, 0, 0, 0);
        write_tar(16'd10);
        TACCR0 = 16'd4;
        push(16'd0, 1, 0, 0);
        tick();
        drain("up_lowered");
        pulse_fclr();
        TACCR0 = 16'd0;
        for (int i = 0; i < 5; i++) tick();
        drain("up_zero");
        chk("up_zero_TAR", {16'h0, TAR}, 32'd0);
        chk("up_zero_TAIFG", {31'h0, TAIFG}, 32'd0);

        // wTACLR collides with a tick at TAR = 5 (up/down, TACCR0 = 5)
        MC = 2'b11; TACCR0 = 16'd5;
        cyc(2);
        push(16'd5, 0, 0, 0);
        write_tar(16'd5);
        drain("coll_load");
        push(16'd0, 0, 0, 0);
        tick_with(1'b1);
        cyc(4);
        drain("collision");
        chk("coll_TAR", {16'h0, TAR}, 32'd0);
        chk("coll_dir", {31'h0, dir}, 32'd0);

        // Stop mode discards ticks
        MC = 2'b00;
        cyc(2);
        push(16'd7, 0, 0, 0);
        write_tar(16'd7);
        drain("stop_load");
        for (int i = 0; i < 4; i++) tick();
        chk("stop_TAR", {16'h0, TAR}, 32'd7);
        MC = 2'b10;
        cyc(6);
        chk("stop_not_queued", {16'h0, TAR}, 32'd7);
        push(16'd8, 0, 0, 0);
        tick();
        drain("resume");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

`default_nettype wire
